// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl
// Brief    : Programmable countdown timer with prescaler, pause, abort and
//            optional auto-reload; emits a one-cycle done pulse at terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               auto_reload,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               paused,
    output logic               done
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_paused = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic [PRESC_W-1:0] r_pcnt;
    logic [WIDTH-1:0]   r_load;
    logic [PRESC_W-1:0] r_presc;
    logic               r_auto;
    logic               r_done;

    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_out_nxt;
    logic [PRESC_W-1:0] w_pcnt_nxt;
    logic [WIDTH-1:0]   w_load_nxt;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic               w_auto_nxt;
    logic               w_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_out   <= '0;
            r_pcnt  <= '0;
            r_load  <= '0;
            r_presc <= '0;
            r_auto  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_load  <= w_load_nxt;
            r_presc <= w_presc_nxt;
            r_auto  <= w_auto_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_pcnt_nxt  = r_pcnt;
        w_load_nxt  = r_load;
        w_presc_nxt = r_presc;
        w_auto_nxt  = r_auto;
        w_done_nxt  = 1'b0;

        if (abort) begin
            w_state_nxt = c_st_idle;
            w_out_nxt   = '0;
            w_pcnt_nxt  = '0;
        end else if (start) begin
            w_state_nxt = c_st_run;
            w_out_nxt   = load_val;
            w_pcnt_nxt  = '0;
            w_load_nxt  = load_val;
            w_presc_nxt = prescale;
            w_auto_nxt  = auto_reload;
        end else begin
            case (r_state)
                c_st_idle: ;
                c_st_run, c_st_paused: begin
                    if (pause) begin
                        w_state_nxt = c_st_paused;
                    end else begin
                        // Leaving PAUSED counts on the same edge so no cycle is lost.
                        w_state_nxt = c_st_run;
                        if (r_pcnt == r_presc) begin
                            w_pcnt_nxt = '0;
                            if (r_out != '0) begin
                                w_out_nxt = r_out - WIDTH'(1);
                            end else begin
                                w_done_nxt = 1'b1;
                                if (r_auto) begin
                                    w_out_nxt = r_load;
                                end else begin
                                    w_state_nxt = c_st_idle;
                                end
                            end
                        end else begin
                            w_pcnt_nxt = r_pcnt + PRESC_W'(1);
                        end
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    assign out    = r_out;
    assign done   = r_done;
    assign busy   = (r_state == c_st_run) || (r_state == c_st_paused);
    assign paused = (r_state == c_st_paused);

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_ctrl
// Brief    : Self-checking bench for countdown_ctrl against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   load_val;
    logic [PRESC_W-1:0] prescale;
    logic               auto_reload;
    logic               pause;
    logic               abort;
    logic [WIDTH-1:0]   out;
    logic               busy;
    logic               paused;
    logic               done;

    countdown_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_val    (load_val),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .out         (out),
        .busy        (busy),
        .paused      (paused),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: elapsed counts active (unpaused) cycles since start/reload;
    // out follows from how many whole prescale periods have elapsed.
    bit m_active, m_paused, m_done, m_ar;
    int m_out, m_el, m_ld, m_ps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int p, t;
        m_done = 1'b0;
        if (reset) begin
            m_active = 0; m_paused = 0; m_out = 0; m_el = 0;
            m_ld = 0; m_ps = 0; m_ar = 0;
        end else if (abort) begin
            m_active = 0; m_paused = 0; m_out = 0; m_el = 0;
        end else if (start) begin
            m_ld = int'(load_val); m_ps = int'(prescale); m_ar = auto_reload;
            m_active = 1; m_paused = 0; m_el = 0; m_out = m_ld;
        end else if (m_active) begin
            if (pause) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                p = m_ps + 1;
                t = (m_ld + 1) * p;
                m_el++;
                if (m_el == t) begin
                    m_done = 1;
                    m_el = 0;
                    if (m_ar) m_out = m_ld;
                    else begin m_active = 0; m_out = 0; end
                end else begin
                    m_out = m_ld - m_el / p;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out",    32'(out),    32'(m_out));
        chk("busy",   32'(busy),   32'(m_active));
        chk("paused", 32'(paused), 32'(m_paused));
        chk("done",   32'(done),   32'(m_done));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic go(input int lv, input int ps, input bit ar);
        load_val = WIDTH'(lv); prescale = PRESC_W'(ps); auto_reload = ar;
        start = 1'b1;
        step();
        start = 1'b0;
        // Mid-run changes must be ignored until the next start.
        load_val = WIDTH'($urandom); prescale = PRESC_W'($urandom); auto_reload = 1'($urandom);
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 0; abort = 0; pause = 0; auto_reload = 0;
        load_val = '0; prescale = '0;
        m_active = 0; m_paused = 0; m_done = 0; m_ar = 0;
        m_out = 0; m_el = 0; m_ld = 0; m_ps = 0;

        steps(2);
        reset = 1'b0;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        steps(20);

        go(3, 0, 0);
        chk("first_out", 32'(out), 32'd3);
        steps(8);

        go(2, 2, 1);
        steps(30);
        abort = 1'b1; step(); abort = 1'b0;

        go(5, 0, 0);
        steps(2);
        chk("pause_at3", 32'(out), 32'd3);
        pause = 1'b1; steps(4); pause = 1'b0;
        steps(8);

        go(9, 0, 0);
        steps(5);
        go(6, 0, 0);
        chk("restart", 32'(out), 32'd6);
        steps(4);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_out", 32'(out), 32'd0);
        steps(3);

        go(7, 1, 0);
        steps(3);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        steps(3);

        go(0, 0, 0);
        steps(3);

        go(15, 15, 0);
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (done) begin lat = i; break; end
        end
        chk("lat256", 32'(lat), 32'd256);
        steps(3);

        pause = 1'b1; steps(3); pause = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom % 500) == 0;
            abort = ($urandom % 100) == 0;
            start = ($urandom % 25) == 0;
            if (($urandom % 12) == 0) pause = ~pause;
            load_val = WIDTH'($urandom);
            prescale = (($urandom % 4) == 0) ? PRESC_W'($urandom) : PRESC_W'($urandom % 3);
            auto_reload = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Controller that sequences a WIDTH-bit down counter as a programmable countdown timer.
- Latches a load value and a prescale setting on start, then decrements the counter once per prescaled tick.
- Supports level-sensitive pause, abort, and optional auto-reload.
- Raises a one-cycle done pulse at each terminal count.
- Used by higher-level blocks as a shared delay/interval timer.

Parameters:
- WIDTH, 4, bit width of the count value (load_val, out).
- PRESC_W, 4, bit width of the prescale setting and the internal prescale counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse or level; sampled each edge; loads and (re)starts the countdown.
- load_val  input  WIDTH  initial count, latched when start is accepted.
- prescale  input  PRESC_W  tick divider, latched on start; one tick every prescale+1 cycles.
- auto_reload  input  1  latched on start; when 1, reload after terminal count instead of stopping.
- pause  input  1  level; while high in RUN/PAUSED, counting is frozen.
- abort  input  1  pulse; stops the timer without done.
- out  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSED.
- paused  output  1  high in PAUSED.
- done  output  1  one-cycle pulse at terminal count (registered).

Behaviour:
- Reset (synchronous, active-high) clears all state:
  - state=IDLE, out=0, busy=0, paused=0, done=0.
  - Internal prescale counter (pcnt)=0; latched load, prescale and auto_reload registers=0.
- States: IDLE, RUN, PAUSED. busy and paused are decoded combinationally from the registered state.
- Priority at each edge: reset > abort > start > pause > normal counting.
- abort (any state):
  - next state IDLE, out<=0, pcnt<=0, done stays 0.
  - abort together with start: abort wins, start is ignored.
- start (any state, no abort):
  - Latches load_val, prescale and auto_reload.
  - out<=load_val, pcnt<=0, next state RUN.
  - start while RUN or PAUSED restarts the count; no done is issued for the interrupted count.
- Tick definition:
  - In RUN with pause=0: when pcnt==latched prescale, tick=1 and pcnt<=0; otherwise pcnt<=pcnt+1.
  - prescale=0 gives a tick every cycle.
- On tick with out!=0: out<=out-1.
- On tick with out==0 (terminal count):
  - done<=1 for exactly one cycle.
  - If latched auto_reload=1: out<=latched load, stay RUN.
  - Otherwise: next state IDLE, out holds 0.
- Latency: with prescale=0 and load N, out is N at edge k (start sampled), reaches 0 at k+N, and done is high for the cycle after edge k+N+1. Period is (N+1)*(prescale+1) cycles.
- load_val=0: out=0 after start; done after prescale+1 cycles.
- Pause:
  - In RUN, pause=1 at an edge: next state PAUSED; out and pcnt are held.
  - In PAUSED, pause=0 at an edge: next state RUN; counting resumes from the held pcnt, so no cycles are lost or gained.
  - pause in IDLE is ignored.
- IDLE: out holds its last value; no ticks.
- Changing load_val, prescale or auto_reload mid-run has no effect until the next start.
- No wrap-around below 0: out never decrements from 0.
- Arithmetic: decrement and increment are unsigned, modulo width, guarded by the conditions above.
- done is never asserted in the same cycle as reset, abort or start restart.

Test Plan:
- Reset for 2 cycles, then release -> out=0, busy=0, paused=0, done=0; with no start, all outputs stay constant for 20 cycles.
- start 1 cycle, load_val=3, prescale=0, auto_reload=0 -> out=3,2,1,0 on successive edges; done high exactly one cycle after out reaches 0; then busy=0 and out stays 0.
- load_val=2, prescale=2, auto_reload=1 -> out holds each value 3 cycles; sequence 2,1,0,2,1,0; done pulses every 9 cycles; busy stays 1.
- load_val=5, prescale=0; pause high for 4 cycles while out=3 -> paused=1, out stays 3 for those cycles; after release, countdown resumes 2,1,0; done is 4 cycles later than the unpaused case.
- Restart and abort:
  - load_val=9: start again at out=4 with load_val=6 -> out=6 next edge, no done for the first count.
  - abort at out=2 -> out=0, busy=0, no done.
  - start and abort in the same cycle -> IDLE.
- Edge cases:
  - load_val=0, prescale=0 -> done pulse one cycle after start.
  - load_val=15 (max), prescale=15 -> done after 256 cycles.
